// File: rtl/fp_square_if.sv
// Handshake bundle for fp_square: go/in from the controller, out/done from the squarer.
interface fp_square_if #(
    parameter int WIDTH = 32
);
    logic             go;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             done;

    // Controller side: issues go/in, observes out/done.
    modport master (
        output go,
        output in,
        input  out,
        input  done
    );

    // Squarer side.
    modport slave (
        input  go,
        input  in,
        output out,
        output done
    );
endinterface

// File: rtl/fp_square.sv
// fp_square: multi-cycle unsigned fixed-point squarer, out = (in*in) >> FRAC_WIDTH.
// Radix-2 shift-add: one multiplier bit per BUSY cycle, WIDTH BUSY cycles per operation.
// Optional macro FP_SQUARE_SATURATE_EN: clamp out to all ones when the product
// overflows the WIDTH-bit result instead of wrapping.
module fp_square #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    fp_square_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam bit FORMAT_OK = (INT_WIDTH + FRAC_WIDTH == WIDTH);

    // Without saturation the bits above WIDTH+FRAC_WIDTH are discarded anyway, so the
    // accumulator only needs to be that wide; modular addition keeps the kept bits exact.
`ifdef FP_SQUARE_SATURATE_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH + FRAC_WIDTH;
`endif

    generate
        if (!FORMAT_OK) begin : g_bad_format
            $error("fp_square: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               load;
    logic               step;
    logic               finish;

    logic [ACC_W-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   out_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   result;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, run WIDTH steps, one DONE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.go) state_next = BUSY;
            BUSY:    if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        case (state_reg)
            IDLE:    load   = bus.go;
            BUSY:    step   = 1'b1;
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

    // Result selection: drop the FRAC_WIDTH low bits, wrap or clamp the top.
    always_comb begin
        result = acc_reg[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
`ifdef FP_SQUARE_SATURATE_EN
        if (|acc_reg[2*WIDTH-1:WIDTH+FRAC_WIDTH]) begin
            result = {WIDTH{1'b1}};
        end
`endif
    end

    // Shift-add datapath; mcand is shifted in place so no barrel shifter is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            out_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= finish;
            if (load) begin
                mcand_reg  <= ACC_W'(bus.in);
                mplier_reg <= bus.in;
                acc_reg    <= '0;
                cnt_reg    <= '0;
            end else if (step) begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CNT_W'(1);
            end
            if (finish) begin
                out_reg <= result;
            end
        end
    end

    assign bus.out  = out_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_fp_square.sv
// Bench for fp_square: a 32-bit Q16.16 instance and an 8-bit integer instance,
// each tracked by a latency/arithmetic model and compared every cycle.
module tb_fp_square;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fp_square_if #(.WIDTH(32)) bus32 ();
    fp_square_if #(.WIDTH(8))  bus8 ();

    fp_square #(.WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16)) dut32 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus32)
    );

    fp_square #(.WIDTH(8), .INT_WIDTH(8), .FRAC_WIDTH(0)) dut8 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FP_SQUARE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Reference arithmetic: full product, truncate, then wrap or clamp.
    function automatic logic [31:0] sq_model(input logic [31:0] x, input int w, input int f);
        logic [63:0] p;
        logic [63:0] mask;
        logic [63:0] r;
        p    = {32'd0, x} * {32'd0, x};
        mask = (64'd1 << w) - 64'd1;
        r    = (p >> f) & mask;
        if (SAT && ((p >> (w + f)) != 64'd0)) r = mask;
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Models: accept when idle, result appears WIDTH+1 edges after acceptance.
    int          m32_cnt;
    logic [31:0] m32_pend;
    logic [31:0] m32_out;
    logic        m32_done;
    int          m8_cnt;
    logic [31:0] m8_pend;
    logic [31:0] m8_out;
    logic        m8_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m32_cnt <= 0; m32_pend <= 0; m32_out <= 0; m32_done <= 1'b0;
        end else if (m32_cnt != 0) begin
            m32_cnt  <= m32_cnt - 1;
            m32_done <= (m32_cnt == 1);
            if (m32_cnt == 1) m32_out <= m32_pend;
        end else begin
            m32_done <= 1'b0;
            if (bus32.go) begin
                m32_cnt  <= 33;
                m32_pend <= sq_model(bus32.in, 32, 16);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8_cnt <= 0; m8_pend <= 0; m8_out <= 0; m8_done <= 1'b0;
        end else if (m8_cnt != 0) begin
            m8_cnt  <= m8_cnt - 1;
            m8_done <= (m8_cnt == 1);
            if (m8_cnt == 1) m8_out <= m8_pend;
        end else begin
            m8_done <= 1'b0;
            if (bus8.go) begin
                m8_cnt  <= 9;
                m8_pend <= sq_model({24'd0, bus8.in}, 8, 0);
            end
        end
    end

    // Cycle-by-cycle comparison of both DUTs against their models.
    always @(negedge clk) begin
        check("cyc_done32", {31'd0, bus32.done}, {31'd0, m32_done});
        check("cyc_out32", bus32.out, m32_out);
        check("cyc_done8", {31'd0, bus8.done}, {31'd0, m8_done});
        check("cyc_out8", {24'd0, bus8.out}, m8_out);
    end

    // Wait (bounded) for done on the 32-bit DUT; returns cycles waited.
    task automatic wait_done32(output int k);
        k = 0;
        while (bus32.done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run32(input logic [31:0] x, input logic [31:0] want, input string name);
        int k;
        bus32.go = 1'b1;
        bus32.in = x;
        @(negedge clk);
        bus32.go = 1'b0;
        bus32.in = $urandom();
        wait_done32(k);
        $display("op32 %s in=%h out=%h want=%h cycles=%0d", name, x, bus32.out, want, k);
        check({name, "_lat"}, k, 33);
        check(name, bus32.out, want);
        @(negedge clk);
        check({name, "_pulse"}, {31'd0, bus32.done}, 32'd0);
        check({name, "_hold"}, bus32.out, want);
    endtask

    task automatic run8(input logic [7:0] x, input logic [7:0] want, input string name);
        int k;
        bus8.go = 1'b1;
        bus8.in = x;
        @(negedge clk);
        bus8.go = 1'b0;
        bus8.in = 8'($urandom());
        k = 0;
        while (bus8.done !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        $display("op8 %s in=%0d out=%0d want=%0d cycles=%0d", name, x, bus8.out, want, k);
        check({name, "_lat"}, k, 9);
        check(name, {24'd0, bus8.out}, {24'd0, want});
        @(negedge clk);
        check({name, "_pulse"}, {31'd0, bus8.done}, 32'd0);
    endtask

    initial begin
        int k;
        rst      = 1'b1;
        bus32.go = 1'b0;
        bus32.in = '0;
        bus8.go  = 1'b0;
        bus8.in  = '0;
        repeat (3) @(negedge clk);
        check("rst_out32", bus32.out, 32'd0);
        check("rst_done32", {31'd0, bus32.done}, 32'd0);
        check("rst_out8", {24'd0, bus8.out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run32(32'h0003_0000, 32'h0009_0000, "sq3");
        run32(32'h0000_8000, 32'h0000_4000, "half");
        run32(32'h0000_0001, 32'h0000_0000, "lsb_trunc");
        run32(32'h0001_8000, 32'h0002_4000, "one_p5");
        run32(32'h0100_0000, SAT ? 32'hFFFF_FFFF : 32'h0000_0000, "ovf256");
        run32(32'hFFFF_FFFF, SAT ? 32'hFFFF_FFFF : 32'hFFFE_0000, "max");

        run8(8'd15, 8'd225, "i15");
        run8(8'd16, SAT ? 8'd255 : 8'd0, "i16_ovf");
        run8(8'd255, SAT ? 8'd255 : 8'd1, "i255");
        run8(8'd1, 8'd1, "i1");

        // Back-to-back: go held through the first operation, new operand at done.
        bus32.go = 1'b1;
        bus32.in = 32'h0002_0000;
        @(negedge clk);
        bus32.in = $urandom();
        wait_done32(k);
        $display("op32 b2b_first out=%h cycles=%0d", bus32.out, k);
        check("b2b_first_lat", k, 33);
        check("b2b_first", bus32.out, 32'h0004_0000);
        bus32.in = 32'h0005_0000;
        @(negedge clk);
        bus32.go = 1'b0;
        bus32.in = $urandom();
        wait_done32(k);
        $display("op32 b2b_second out=%h cycles=%0d", bus32.out, k);
        check("b2b_second_lat", k, 33);
        check("b2b_second", bus32.out, 32'h0019_0000);
        @(negedge clk);

        // Reset in the middle of BUSY: out clears at once, no done afterwards.
        bus32.go = 1'b1;
        bus32.in = 32'h0007_0000;
        @(negedge clk);
        bus32.go = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        $display("reset_mid_busy out=%h done=%b", bus32.out, bus32.done);
        check("abort_out", bus32.out, 32'd0);
        check("abort_done", {31'd0, bus32.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done_out", bus32.out, 32'd0);
        run32(32'h0002_0000, 32'h0004_0000, "after_rst");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
